rr_arbiter_8: RTL and testbench

//  Round-robin arbiter sharing one resource (write port / bus slot) among 8 requesters.

---
 rtl/rr_arbiter_8_pkg.sv | 15 +
 rtl/decoder_3_8.sv | 13 +
 rtl/rr_arbiter_8.sv | 114 +++++++++++
 tb/tb_rr_arbiter_8.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

  localparam int unsigned ARB_N     = 8;
  localparam int unsigned ARB_IDX_W = 3;
  localparam int unsigned HOLD_W    = 8;

  // 2'd3 is unused; the FSM recovers to StIdle from it.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StTurn = 2'd2
  } arb_state_e;

endpackage

// File: rtl/decoder_3_8.sv
// 3-to-8 binary to one-hot decoder.
module decoder_3_8 (
  input  logic [2:0] idx,
  output logic [7:0] oh
);

  // Set exactly one bit selected by idx.
  always_comb begin
    oh      = '0;
    oh[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with hold-until-release ownership,
// optional timeout preemption and a one-cycle turnaround bubble between owners.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_N-1:0]     grant_oh,
  output logic [ARB_IDX_W-1:0] grant_idx,
  output logic                 grant_vld,
  output logic                 preempt
);

  localparam bit                TimeoutEn = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HoldLast  = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_e           state_q, state_d;
  logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
  logic [ARB_IDX_W-1:0] owner_q, owner_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 preempt_q, preempt_d;
  logic [ARB_N-1:0]     dec_oh;

  // First requester at or after p, wrapping modulo 8: rotate, priority-encode, add p back.
  function automatic logic [ARB_IDX_W-1:0] pick(input logic [ARB_N-1:0]     r,
                                                input logic [ARB_IDX_W-1:0] p);
    logic [ARB_N-1:0]     rot;
    logic [ARB_IDX_W-1:0] off;
    logic [ARB_IDX_W-1:0] src;
    for (int j = 0; j < int'(ARB_N); j++) begin
      src    = p + ARB_IDX_W'(j);
      rot[j] = r[src];
    end
    off = '0;
    for (int j = int'(ARB_N) - 1; j >= 0; j--) begin
      if (rot[j]) off = ARB_IDX_W'(j);
    end
    return p + off;
  endfunction

  // State registers; async reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  // Next-state logic: grant, hold/release, timeout, turnaround bubble.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d = pick(req, ptr_q);
          hold_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (hold_q != '1) hold_d = hold_q + 1'b1;
        if (!req[owner_q]) begin
          ptr_d   = owner_q + 1'b1;
          state_d = StTurn;
        end else if (TimeoutEn && (hold_q == HoldLast)) begin
          // Moving ptr past the owner makes a still-requesting owner lowest priority.
          ptr_d     = owner_q + 1'b1;
          preempt_d = 1'b1;
          state_d   = StTurn;
        end
      end
      StTurn: begin
        if (|req) begin
          owner_d = pick(req, ptr_q);
          hold_d  = '0;
          state_d = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  decoder_3_8 u_dec (
    .idx (owner_q),
    .oh  (dec_oh)
  );

  // Outputs derive only from registered state.
  always_comb begin
    grant_vld = (state_q == StBusy);
    grant_oh  = dec_oh & {ARB_N{grant_vld}};
    grant_idx = owner_q;
    preempt   = preempt_q;
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: table of per-cycle vectors with a
// scoreboard queue, plus a hand-written async-reset-mid-grant sequence.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, req2;
  logic [7:0] grant_oh, grant_oh2;
  logic [2:0] grant_idx, grant_idx2;
  logic       grant_vld, grant_vld2;
  logic       preempt, preempt2;

  int total = 0;
  int bad   = 0;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .preempt   (preempt)
  );

  rr_arbiter_8 #(.MAX_HOLD(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req2),
    .grant_oh  (grant_oh2),
    .grant_idx (grant_idx2),
    .grant_vld (grant_vld2),
    .preempt   (preempt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;  // pulse reset before applying this vector
    bit         sel;  // 0: dut (MAX_HOLD=4), 1: dut2 (MAX_HOLD=2)
    logic [7:0] req;
    logic       vld;
    logic [2:0] idx;
    logic       pre;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic void add(bit rst, bit sel, logic [7:0] r, logic vld, logic [2:0] idx,
                              logic pre);
    vec_t v;
    v.rst = rst; v.sel = sel; v.req = r; v.vld = vld; v.idx = idx; v.pre = pre;
    vecs.push_back(v);
  endfunction

  // {vld, idx (masked when idle), one-hot, preempt}
  function automatic logic [12:0] pack(logic vld, logic [2:0] idx, logic [7:0] oh, logic pre);
    return {vld, (vld ? idx : 3'd0), oh, pre};
  endfunction

  function automatic logic [12:0] actual(bit sel);
    if (sel) return pack(grant_vld2, grant_idx2, grant_oh2, preempt2);
    return pack(grant_vld, grant_idx, grant_oh, preempt);
  endfunction

  task automatic check(string name, logic [12:0] act, logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got vld/idx/oh/pre=%h want %h", name, act, exp);
    end
  endtask

  task automatic drive(bit sel, logic [7:0] r);
    req  = sel ? 8'h00 : r;
    req2 = sel ? r : 8'h00;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    vec_t       e;
    logic [7:0] eoh;
    if (v.rst) begin
      @(negedge clk);
      rst_n = 1'b0;
      drive(v.sel, v.req);
      #1;
      check($sformatf("reset_v%0d", n), actual(v.sel), 13'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      @(negedge clk);
      drive(v.sel, v.req);
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    eoh = e.vld ? (8'h01 << e.idx) : 8'h00;
    check($sformatf("vec%0d", n), actual(e.sel), pack(e.vld, e.idx, eoh, e.pre));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0;
    req   = 8'h00;
    req2  = 8'h00;

    // Reset with all requesting, then rotation with MAX_HOLD=4: 4 busy + 1 preempt bubble each.
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) add((k == 0 && c == 0), 1'b0, 8'hFF, 1'b1, 3'(k % 8), 1'b0);
      add(1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b1);
    end

    // Release: owner 2 drops after 3 cycles, bubble, then 5; 5 drops -> idle.
    add(1, 0, 8'h24, 1, 3'd2, 0);
    add(0, 0, 8'h24, 1, 3'd2, 0);
    add(0, 0, 8'h24, 1, 3'd2, 0);
    add(0, 0, 8'h20, 0, 3'd0, 0);
    add(0, 0, 8'h20, 1, 3'd5, 0);
    add(0, 0, 8'h20, 1, 3'd5, 0);
    add(0, 0, 8'h00, 0, 3'd0, 0);
    add(0, 0, 8'h00, 0, 3'd0, 0);
    add(0, 0, 8'h00, 0, 3'd0, 0);

    // Wrap: owner 7 releases, ptr wraps to 0 so 0 beats 7; then ptr=1 so 7 beats 0.
    add(1, 0, 8'h80, 1, 3'd7, 0);
    add(0, 0, 8'h81, 1, 3'd7, 0);
    add(0, 0, 8'h01, 0, 3'd0, 0);
    add(0, 0, 8'h81, 1, 3'd0, 0);
    add(0, 0, 8'h81, 1, 3'd0, 0);
    add(0, 0, 8'h80, 0, 3'd0, 0);
    add(0, 0, 8'h81, 1, 3'd7, 0);
    add(0, 0, 8'h00, 0, 3'd0, 0);
    add(0, 0, 8'h00, 0, 3'd0, 0);

    // Single requester 6 with MAX_HOLD=2: BUSY, BUSY, TURN(preempt) repeating.
    for (int k = 0; k < 3; k++) begin
      add((k == 0), 1, 8'h40, 1, 3'd6, 0);
      add(0, 1, 8'h40, 1, 3'd6, 0);
      add(0, 1, 8'h40, 0, 3'd0, 1);
    end

    // Set ptr to 6 and hold owner 6 before the async reset below.
    add(1, 0, 8'h20, 1, 3'd5, 0);
    add(0, 0, 8'h00, 0, 3'd0, 0);
    add(0, 0, 8'h40, 1, 3'd6, 0);
    add(0, 0, 8'h40, 1, 3'd6, 0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Async reset between edges while owner 6 is granted: outputs clear at once.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_busy", actual(1'b0), 13'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h00;
    // ptr must be back at 0, so all-request grants 0 rather than 6.
    v.rst = 1'b0; v.sel = 1'b0; v.req = 8'hFF; v.vld = 1'b1; v.idx = 3'd0; v.pre = 1'b0;
    run_vec(v, 999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
